// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the acc_core accumulator processor.
//   op_e       4-bit opcode enumeration (op 4'hF is the illegal opcode)
//   state_e    sequencer states
//   IMM_BIT, OP_MSB, OP_LSB, F_MSB  instruction field positions
//   writesAcc  true for opcodes that write the accumulator and the Z flag in EXEC
package acc_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_SUB     = 4'h1,
    OP_AND     = 4'h2,
    OP_OR      = 4'h3,
    OP_XOR     = 4'h4,
    OP_SHL     = 4'h5,
    OP_SHR     = 4'h6,
    OP_LDI     = 4'h7,
    OP_MOVT    = 4'h8,
    OP_MOVF    = 4'h9,
    OP_LDM     = 4'hA,
    OP_STM     = 4'hB,
    OP_BEQ     = 4'hC,
    OP_BNE     = 4'hD,
    OP_HALT    = 4'hE,
    OP_ILLEGAL = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int IMM_BIT = 8;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int F_MSB   = 3;

  // LDM also writes ACC/Z, but only when the memory access completes.
  function automatic logic writesAcc(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_LDI, OP_MOVF: writesAcc = 1'b1;
      default:                         writesAcc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational ALU for acc_core.
//   op       in  4   opcode (acc_pkg::op_e encoding)
//   acc      in  DW  accumulator value
//   operand  in  DW  immediate or register operand
//   result   out DW  new accumulator value (mod 2^DW)
//   zero     out 1   result == 0
module acc_alu
  import acc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  output logic [DW-1:0] result,
  output logic          zero
);

  localparam int SW = (DW > 1) ? $clog2(DW) : 1;

  op_e          opS;
  logic [SW-1:0] shamtS;

  assign opS    = op_e'(op);
  // Only the low clog2(DW) operand bits form the shift distance.
  assign shamtS = operand[SW-1:0];

  // Result select; LDI and MOVF pass the operand straight through.
  always_comb begin
    result = acc;
    case (opS)
      OP_ADD:          result = acc + operand;
      OP_SUB:          result = acc - operand;
      OP_AND:          result = acc & operand;
      OP_OR:           result = acc | operand;
      OP_XOR:          result = acc ^ operand;
      OP_SHL:          result = acc << shamtS;
      OP_SHR:          result = acc >> shamtS;
      OP_LDI, OP_MOVF: result = operand;
      default:         result = acc;
    endcase
  end

  assign zero = (result == {DW{1'b0}});

endmodule

// File: rtl/acc_core.sv
// acc_core: multi-cycle accumulator processor (FETCH / EXEC / MEM_WAIT).
//   clk, init_n            clock, asynchronous active-low reset
//   req, prog_sel, ack     four-phase start handshake; prog_sel picks the program
//   err                    illegal opcode or PC overflow, valid with ack
//   imem_addr, imem_data   instruction ROM (combinational read)
//   jt_idx, jt_target      jump table (combinational)
//   dmem_*                 data memory with wait-state handshake (dmem_ready)
//   cycle_ct               executed-cycle count, built only when
//                          ACC_CORE_CYCLE_CNT_EN is defined (else tied to 0)
module acc_core
  import acc_pkg::*;
#(
  parameter int DW       = 8,
  parameter int RF_DEPTH = 16,
  parameter int PC_W     = 10,
  parameter int MEM_AW   = 8,
  parameter int NPROG    = 4,
  parameter int PROG_STR = 256
) (
  input  logic                                      clk,
  input  logic                                      init_n,
  input  logic                                      req,
  input  logic [((NPROG > 1) ? $clog2(NPROG) : 1)-1:0] prog_sel,
  output logic                                      ack,
  output logic                                      err,
  output logic [PC_W-1:0]                           imem_addr,
  input  logic [8:0]                                imem_data,
  output logic [3:0]                                jt_idx,
  input  logic [PC_W-1:0]                           jt_target,
  output logic                                      dmem_req,
  output logic                                      dmem_we,
  output logic [MEM_AW-1:0]                         dmem_addr,
  output logic [DW-1:0]                             dmem_wdata,
  input  logic [DW-1:0]                             dmem_rdata,
  input  logic                                      dmem_ready,
  output logic [15:0]                               cycle_ct
);

  localparam int RW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
  localparam logic [RW-1:0] ACC_IDX = RW'(RF_DEPTH - 1);

  state_e          stateR, nextStateS;
  logic [PC_W-1:0] pcR;
  logic [8:0]      irR;
  logic [DW-1:0]   regR [RF_DEPTH];
  logic            zR, ackR, errR, dmemReqR, dmemWeR;
  logic [MEM_AW-1:0] dmemAddrR;
  logic [DW-1:0]   dmemWdataR;

  op_e             opS;
  logic [RW-1:0]   fIdxS;
  logic [DW-1:0]   accS, regFS, operandS, aluResS;
  logic            aluZeroS, branchS, pcAtMaxS, accWriteS;
  logic [PC_W-1:0] pcIncS, startPcS;
  logic [31:0]     progIdxS;

  assign opS       = op_e'(irR[OP_MSB:OP_LSB]);
  assign fIdxS     = irR[RW-1:0];
  assign accS      = regR[ACC_IDX];
  assign regFS     = regR[fIdxS];
  // MOVF always reads the register, whatever the imm bit says.
  assign operandS  = (opS == OP_MOVF || !irR[IMM_BIT]) ? regFS : DW'(irR[F_MSB:0]);
  assign accWriteS = writesAcc(opS);
  assign branchS   = ((opS == OP_BEQ) && zR) || ((opS == OP_BNE) && !zR);
  assign pcIncS    = pcR + PC_W'(1);
  // PC never wraps: stepping past the top address ends the run with err.
  assign pcAtMaxS  = &pcR;
  // Out-of-range program selects fall back to program 0.
  assign progIdxS  = (32'(prog_sel) < 32'(NPROG)) ? 32'(prog_sel) : 32'd0;
  assign startPcS  = PC_W'(progIdxS * 32'(PROG_STR));

  acc_alu #(.DW(DW)) u_alu (
    .op      (irR[OP_MSB:OP_LSB]),
    .acc     (accS),
    .operand (operandS),
    .result  (aluResS),
    .zero    (aluZeroS)
  );

  // State register.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) stateR <= ST_IDLE;
    else         stateR <= nextStateS;
  end

  // Next-state decode.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      ST_IDLE: begin
        if (req) nextStateS = ST_FETCH;
        else     nextStateS = ST_IDLE;
      end
      ST_FETCH: nextStateS = ST_EXEC;
      ST_EXEC: begin
        case (opS)
          OP_LDM, OP_STM:      nextStateS = ST_MEM_WAIT;
          OP_HALT, OP_ILLEGAL: nextStateS = ST_DONE;
          default: begin
            if (!branchS && pcAtMaxS) nextStateS = ST_DONE;
            else                      nextStateS = ST_FETCH;
          end
        endcase
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready)   nextStateS = ST_MEM_WAIT;
        else if (pcAtMaxS) nextStateS = ST_DONE;
        else               nextStateS = ST_FETCH;
      end
      ST_DONE: begin
        if (!req) nextStateS = ST_IDLE;
        else      nextStateS = ST_DONE;
      end
      default: nextStateS = ST_IDLE;
    endcase
  end

  // Datapath: PC, IR, register file, flags, memory request and handshake outputs.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      pcR        <= {PC_W{1'b0}};
      irR        <= 9'h000;
      zR         <= 1'b0;
      ackR       <= 1'b0;
      errR       <= 1'b0;
      dmemReqR   <= 1'b0;
      dmemWeR    <= 1'b0;
      dmemAddrR  <= {MEM_AW{1'b0}};
      dmemWdataR <= {DW{1'b0}};
      for (int i = 0; i < RF_DEPTH; i++) regR[i] <= {DW{1'b0}};
    end else begin
      case (stateR)
        ST_IDLE: begin
          if (req) pcR <= startPcS;
        end
        ST_FETCH: irR <= imem_data;
        ST_EXEC: begin
          case (opS)
            OP_LDM, OP_STM: begin
              // Address and data are captured once and held for the whole wait.
              dmemReqR   <= 1'b1;
              dmemWeR    <= (opS == OP_STM);
              dmemAddrR  <= MEM_AW'(regFS);
              dmemWdataR <= accS;
            end
            OP_HALT: ackR <= 1'b1;
            OP_ILLEGAL: begin
              ackR <= 1'b1;
              errR <= 1'b1;
            end
            default: begin
              if (accWriteS) begin
                regR[ACC_IDX] <= aluResS;
                zR            <= aluZeroS;
              end
              // MOVT onto the accumulator index rewrites ACC with itself.
              if (opS == OP_MOVT) regR[fIdxS] <= accS;
              if (branchS) pcR <= jt_target;
              else if (pcAtMaxS) begin
                ackR <= 1'b1;
                errR <= 1'b1;
              end else pcR <= pcIncS;
            end
          endcase
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            dmemReqR <= 1'b0;
            dmemWeR  <= 1'b0;
            if (!dmemWeR) begin
              regR[ACC_IDX] <= dmem_rdata;
              zR            <= (dmem_rdata == {DW{1'b0}});
            end
            if (pcAtMaxS) begin
              ackR <= 1'b1;
              errR <= 1'b1;
            end else pcR <= pcIncS;
          end
        end
        ST_DONE: begin
          if (!req) begin
            ackR <= 1'b0;
            errR <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack        = ackR;
  assign err        = errR;
  assign imem_addr  = pcR;
  assign jt_idx     = irR[3:0];
  assign dmem_req   = dmemReqR;
  assign dmem_we    = dmemWeR;
  assign dmem_addr  = dmemAddrR;
  assign dmem_wdata = dmemWdataR;

`ifdef ACC_CORE_CYCLE_CNT_EN
  logic [15:0] cycleCtR;

  // Run-length counter: cleared at start, counts FETCH/EXEC/MEM_WAIT cycles, saturates.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cycleCtR <= 16'h0000;
    end else if (stateR == ST_IDLE) begin
      if (req) cycleCtR <= 16'h0000;
    end else if (stateR != ST_DONE && cycleCtR != 16'hFFFF) begin
      cycleCtR <= cycleCtR + 16'h0001;
    end
  end

  assign cycle_ct = cycleCtR;
`else
  assign cycle_ct = 16'h0000;
`endif

endmodule

// File: tb/tb_acc_core.sv
// Scoreboard bench for acc_core: program runs push expected ack records and
// expected data-memory accesses into queues; a monitor pops and compares them
// whenever the DUT raises ack or presents a memory request.
module tb_acc_core;
  import acc_pkg::*;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } memExp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] lat;
  } ackExp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic init_n, req, ack, err, dmem_req, dmem_we, dmem_ready;
  logic [1:0]  prog_sel;
  logic [9:0]  imem_addr, jt_target;
  logic [8:0]  imem_data;
  logic [3:0]  jt_idx;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] cycle_ct;

  logic        req2, ack2, err2, dmem_req2, dmem_we2;
  logic [1:0]  prog_sel2;
  logic [3:0]  imem_addr2, jt_idx2;
  logic [7:0]  dmem_addr2, dmem_wdata2;
  logic [15:0] cycle_ct2;

  logic [8:0] imem [1024];
  logic [9:0] jt [16];
  logic [7:0] dmem [256];
  logic [8:0] imem2 [16];

  memExp_t memQ [$];
  ackExp_t ackQ [$];
  int checks = 0, failures = 0;
  int cyc = 0, startEdge = 0, memLat = 0, waitCnt = 0;
  logic ackPrev = 1'b0;

  assign imem_data  = imem[imem_addr];
  assign jt_target  = jt[jt_idx];
  assign dmem_rdata = dmem[dmem_addr];

  acc_core dut (
    .clk(clk), .init_n(init_n), .req(req), .prog_sel(prog_sel), .ack(ack), .err(err),
    .imem_addr(imem_addr), .imem_data(imem_data), .jt_idx(jt_idx), .jt_target(jt_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .cycle_ct(cycle_ct)
  );

  acc_core #(.PC_W(4)) dut2 (
    .clk(clk), .init_n(init_n), .req(req2), .prog_sel(prog_sel2), .ack(ack2), .err(err2),
    .imem_addr(imem_addr2), .imem_data(imem2[imem_addr2]), .jt_idx(jt_idx2), .jt_target(4'h0),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_rdata(8'h00), .dmem_ready(1'b0), .cycle_ct(cycle_ct2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Data memory: raise dmem_ready after memLat extra cycles of an outstanding request.
  always @(posedge clk) begin
    #1;
    if (dmem_req) begin
      dmem_ready = (waitCnt >= memLat);
      waitCnt++;
    end else begin
      dmem_ready = 1'b0;
      waitCnt = 0;
    end
  end

  // Monitor: checks memory requests and ack events against the expectation queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!init_n) begin
        ackPrev = 1'b0;
      end else begin
        if (dmem_req) begin
          if (memQ.size() == 0) begin
            chk("dmem_unexpected_req", 32'(dmem_req), 32'd0);
          end else begin
            chk("dmem_we", 32'(dmem_we), 32'(memQ[0].we));
            chk("dmem_addr", 32'(dmem_addr), 32'(memQ[0].addr));
            if (memQ[0].we) chk("dmem_wdata", 32'(dmem_wdata), 32'(memQ[0].data));
            if (dmem_ready) begin
              if (dmem_we) dmem[dmem_addr] = dmem_wdata;
              void'(memQ.pop_front());
            end
          end
        end
        if (ack && !ackPrev) begin
          if (ackQ.size() == 0) begin
            chk("ack_unexpected", 32'(ack), 32'd0);
          end else begin
            ackExp_t e;
            e = ackQ.pop_front();
            chk("ack_err", 32'(err), 32'(e.err));
            chk("ack_latency", 32'(cyc - startEdge), e.lat);
`ifdef ACC_CORE_CYCLE_CNT_EN
            chk("cycle_ct", 32'(cycle_ct), e.lat);
`else
            chk("cycle_ct", 32'(cycle_ct), 32'd0);
`endif
          end
        end
        ackPrev = ack;
      end
    end
  end

  task automatic pushMem(input logic we, input logic [7:0] addr, input logic [7:0] data);
    memExp_t m;
    m.we = we; m.addr = addr; m.data = data;
    memQ.push_back(m);
  endtask

  task automatic runProg(input logic [1:0] sel, input logic [9:0] startPc, input logic expErr,
                         input int expLat, input int holdCycles);
    ackExp_t e;
    int n;
    e.err = expErr; e.lat = 32'(expLat);
    ackQ.push_back(e);
    @(posedge clk); #1;
    prog_sel = sel; req = 1'b1; startEdge = cyc + 1;
    @(posedge clk); #1;
    chk("start_pc", 32'(imem_addr), 32'(startPc));
    n = 0;
    while (!ack && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_seen", 32'(ack), 32'd1);
    if (holdCycles > 0) begin
      repeat (holdCycles) @(posedge clk);
      #1;
      chk("ack_hold", 32'(ack), 32'd1);
      chk("err_hold", 32'(err), 32'(expErr));
    end
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_clear", 32'(ack), 32'd0);
    chk("err_clear", 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) imem[i] = 9'h0E0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) jt[i] = 10'h000;
    for (int i = 0; i < 16; i++) imem2[i] = 9'h101;
    init_n = 1'b0; req = 1'b0; prog_sel = 2'd0; req2 = 1'b0; prog_sel2 = 2'd0;
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    init_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
    chk("rst_jt_idx", 32'(jt_idx), 32'd0);
    chk("rst_cycle_ct", 32'(cycle_ct), 32'd0);

    // LDI 5; ADD #3; HALT -> ACC=8, Z=0
    imem[0] = 9'h175; imem[1] = 9'h103; imem[2] = 9'h0E0;
    runProg(2'd0, 10'h000, 1'b0, 6, 0);
    // STM R0 exposes ACC=8; BNE taken because Z=0 -> 0x120
    imem[10'h100] = 9'h0B0; imem[10'h101] = 9'h0D2; imem[10'h102] = 9'h0E0;
    imem[10'h120] = 9'h0E0; jt[2] = 10'h120;
    pushMem(1'b1, 8'h00, 8'h08);
    runProg(2'd1, 10'h100, 1'b0, 7, 0);
    chk("bne_taken_pc", 32'(imem_addr), 32'h120);
    chk("acc8_in_mem", 32'(dmem[0]), 32'h08);

    // LDI 8; SUB #8 -> Z=1; BEQ -> 0x010
    imem[10'h200] = 9'h178; imem[10'h201] = 9'h118; imem[10'h202] = 9'h0C1; imem[10'h203] = 9'h0E0;
    jt[1] = 10'h010;
    runProg(2'd2, 10'h200, 1'b0, 8, 0);
    chk("beq_taken_pc", 32'(imem_addr), 32'h010);
    // LDI 7; SUB #8 -> 0xFF, Z=0; BEQ falls through to 0x303
    imem[10'h300] = 9'h177; imem[10'h301] = 9'h118; imem[10'h302] = 9'h0C1; imem[10'h303] = 9'h0E0;
    runProg(2'd3, 10'h300, 1'b0, 8, 0);
    chk("beq_fall_pc", 32'(imem_addr), 32'h303);

    // R2=0x40, ACC=0xA5; STM R2 / LDM R2 / STM R0 with 3-cycle ready delay
    imem[0] = 9'h174; imem[1] = 9'h154; imem[2] = 9'h082; imem[3] = 9'h17A;
    imem[4] = 9'h154; imem[5] = 9'h135; imem[6] = 9'h0B2; imem[7] = 9'h170;
    imem[8] = 9'h0A2; imem[9] = 9'h0B0; imem[10] = 9'h0E0;
    memLat = 3;
    pushMem(1'b1, 8'h40, 8'hA5);
    pushMem(1'b0, 8'h40, 8'hA5);
    pushMem(1'b1, 8'h00, 8'hA5);
    runProg(2'd0, 10'h000, 1'b0, 34, 0);
    chk("stm_mem40", 32'(dmem[8'h40]), 32'hA5);

    // Shift/logic/register-operand checks: SHL #9 shifts by 1
    imem[0] = 9'h173; imem[1] = 9'h159; imem[2] = 9'h0B0; imem[3] = 9'h14F;
    imem[4] = 9'h12D; imem[5] = 9'h161; imem[6] = 9'h032; imem[7] = 9'h0B0;
    imem[8] = 9'h092; imem[9] = 9'h0B0; imem[10] = 9'h012; imem[11] = 9'h0C3;
    imem[10'h020] = 9'h0E0; jt[3] = 10'h020;
    memLat = 0;
    pushMem(1'b1, 8'h00, 8'h06);
    pushMem(1'b1, 8'h00, 8'h44);
    pushMem(1'b1, 8'h00, 8'h40);
    runProg(2'd0, 10'h000, 1'b0, 29, 0);
    chk("sub_reg_beq_pc", 32'(imem_addr), 32'h020);

    // Illegal opcode at program 2 start; DONE held while req stays high
    imem[10'h200] = 9'h0F0;
    runProg(2'd2, 10'h200, 1'b1, 2, 3);

    // Reset during MEM_WAIT
    imem[10'h100] = 9'h177; imem[10'h101] = 9'h0B0; imem[10'h102] = 9'h0E0;
    memLat = 10;
    pushMem(1'b1, 8'h00, 8'h07);
    @(posedge clk); #1;
    prog_sel = 2'd1; req = 1'b1;
    n = 0;
    while (!dmem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_test_req_seen", 32'(dmem_req), 32'd1);
    @(posedge clk); #2;
    init_n = 1'b0;
    #1;
    chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
    memQ.delete();
    ackQ.delete();
    req = 1'b0;
    @(posedge clk); #1;
    init_n = 1'b1;
    memLat = 0;

    // Same short program runs normally after the reset
    imem[0] = 9'h175; imem[1] = 9'h103; imem[2] = 9'h0E0;
    runProg(2'd0, 10'h000, 1'b0, 6, 0);

    // PC_W=4: sixteen ADDs run off the end of the address space
    @(posedge clk); #1;
    req2 = 1'b1;
    n = 0;
    while (!ack2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ovf_ack", 32'(ack2), 32'd1);
    chk("ovf_err", 32'(err2), 32'd1);
    chk("ovf_pc_no_wrap", 32'(imem_addr2), 32'hF);
`ifdef ACC_CORE_CYCLE_CNT_EN
    chk("ovf_cycle_ct", 32'(cycle_ct2), 32'd32);
`else
    chk("ovf_cycle_ct", 32'(cycle_ct2), 32'd0);
`endif
    req2 = 1'b0;
    @(posedge clk); #1;
    chk("ovf_ack_clear", 32'(ack2), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("memq_drained", 32'(memQ.size()), 32'd0);
    chk("ackq_drained", 32'(ackQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
